cp0_int_ctrl: RTL and testbench
===============================

Name: cp0_int_ctrl

Overview:
- Coprocessor-0 interrupt/exception controller; the consuming end of the device interrupt lines (DEV_break of timer and other peripherals).
- Latches hardware interrupt requests and masks them with SR.
- Raises IntReq to the CPU, captures the EPC and exception code on entry, and clears EXL on eret.
- Provides mfc0/mtc0 register access.

Parameters:
- PRID_VAL, 32'h0000_4D50, read-only value of PRId (reg 15).
- HANDLER_PC, 32'h0000_4180, exception vector driven on ExcPC.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- A1  input  5  mfc0 read register number
- A2  input  5  mtc0 write register number
- DIn  input  32  mtc0 write data
- We  input  1  mtc0 write enable
- PC  input  32  PC of the instruction in the exception stage (word aligned)
- ExcCodeIn  input  5  synchronous exception code from the pipeline
- EXLSet  input  1  synchronous exception request this cycle
- EXLClr  input  1  eret executed this cycle
- HWInt  input  6  device interrupt lines, HWInt[0] = timer DEV_break
- BadAddr  input  32  faulting address (used only with the optional feature)
- IntReq  output  1  take interrupt/exception now (combinational)
- ExcPC  output  32  HANDLER_PC constant
- EPC  output  32  saved return PC
- DOut  output  32  mfc0 read data (combinational on A1)

Behaviour:
- Registers:
  - SR (12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}
  - Cause (13) = {16'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}
  - EPC (14), 32 bit, bits [1:0] forced to 0
  - PRId (15) = PRID_VAL
- Reset (reset==0 at posedge): SR=0, Cause=0, EPC=0.
  - IntReq=0 after reset because IE=0.
  - Reset overrides every other input in that cycle.
- IP update: IP <= HWInt every cycle, no edge detection. A device must hold its line until serviced. IP is read-only to mtc0.
- Interrupt qualify: IntPend = |(HWInt & IM) & IE & ~EXL. Raw HWInt is used, not the latched IP, for zero-cycle response.
- IntReq = IntPend | (EXLSet & ~EXL).
- State is given by EXL: NORMAL (EXL=0) and HANDLER (EXL=1).
- NORMAL -> HANDLER when IntReq=1 at posedge:
  - EXL<=1 and EPC<=PC.
  - ExcCode<=0 if IntPend, else ExcCodeIn. Interrupt has priority over a simultaneous synchronous exception.
- HANDLER -> NORMAL when EXLClr=1 at posedge: EXL<=0. IM, IE and EPC are unchanged.
- In HANDLER, further EXLSet and interrupts are ignored: IntReq=0, EPC is not overwritten.
- mtc0:
  - We=1, A2=12: IM/EXL/IE <= DIn fields; other bits ignored.
  - A2=14: EPC <= {DIn[31:2], 2'b00}.
  - Writes to 13, 15 or any other number are ignored.
- Simultaneous events in the same cycle:
  - Exception entry beats mtc0 on the EXL and EPC fields. The mtc0 SR write still updates IM/IE.
  - EXLClr together with an mtc0 to SR: EXLClr wins on EXL.
  - EXLClr together with IntReq is impossible: IntReq requires EXL=0. EXLClr while EXL=0 is a no-op.
- mfc0:
  - DOut selects by A1: 12 SR, 13 Cause, 14 EPC, 15 PRId, else 0.
  - Reads reflect register state before the current edge; there is no write-through bypass.

Optional Feature:
- Macro CP0_BADVADDR_EN.
- When defined:
  - Adds BadVAddr (reg 8), reset 0.
  - Loaded with BadAddr on exception entry when ExcCodeIn is 4 (AdEL) or 5 (AdES) and no interrupt is pending.
  - Read via mfc0 A1=8. Read-only to mtc0.
- When undefined:
  - BadAddr input is ignored.
  - mfc0 A1=8 returns 0.

Test Plan:
- Reset held 0 for 2 cycles, then released -> SR=0, Cause=0, EPC=0, IntReq=0. A1=15 reads 32'h00004D50.
- mtc0 SR=32'h0000_0401, HWInt=6'b000001, PC=32'h3008 -> IntReq=1 same cycle. Next cycle: EXL=1, EPC=32'h3008, Cause=32'h0000_0400 (IP[10]=1, ExcCode=0), IntReq=0.
- In HANDLER, EXLSet=1 with ExcCodeIn=10 and PC=32'h3100 -> EPC stays 32'h3008. Then EXLClr=1 -> SR reads 32'h0000_0401. With HWInt still high, IntReq=1 again.
- IE=1, IM=0 (SR=1), HWInt=6'b111111 -> IntReq=0. Cause IP reads 32'h0000_FC00.
- EXLSet=1, ExcCodeIn=12, HWInt active and enabled in the same cycle -> ExcCode=0 (interrupt wins). Repeat with HWInt=0 -> Cause=32'h0000_0030.
- mtc0 EPC=32'h0000_3007 -> reads 32'h0000_3004. With CP0_BADVADDR_EN: EXLSet, ExcCodeIn=4, BadAddr=32'h1235 -> A1=8 reads 32'h1235. Without the macro, A1=8 reads 0.

Source files
------------

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 interrupt/exception controller: SR/Cause/EPC/PRId, interrupt qualify and EPC capture.
// Optional BadVAddr register (reg 8) enabled by defining CP0_BADVADDR_EN.
module cp0_int_ctrl #(
  parameter logic [31:0] PRID_VAL   = 32'h0000_4D50,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC,
  input  logic [4:0]  ExcCodeIn,
  input  logic        EXLSet,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  input  logic [31:0] BadAddr,
  output logic        IntReq,
  output logic [31:0] ExcPC,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} stateT;

  stateT       stateQ, stateD;
  logic [5:0]  imQ, imD;
  logic        ieQ, ieD;
  logic [5:0]  ipQ;
  logic [4:0]  excCodeQ, excCodeD;
  logic [31:0] epcQ, epcD;
  logic        exl;
  logic        intPend;
  logic [31:0] srVal, causeVal;
  logic [31:0] badVAddrVal;
  logic        unusedBits;

  assign exl     = (stateQ == HANDLER);
  // Raw HWInt (not latched IP) gives a zero-cycle interrupt response.
  assign intPend = (|(HWInt & imQ)) & ieQ & ~exl;
  assign IntReq  = intPend | (EXLSet & ~exl);

  assign srVal    = {16'b0, imQ, 8'b0, exl, ieQ};
  assign causeVal = {16'b0, ipQ, 3'b0, excCodeQ, 2'b0};
  assign ExcPC    = HANDLER_PC;
  assign EPC      = epcQ;

  always_comb begin
    stateD   = stateQ;
    imD      = imQ;
    ieD      = ieQ;
    excCodeD = excCodeQ;
    epcD     = epcQ;
    if (We && A2 == 5'd12) begin
      imD    = DIn[15:10];
      ieD    = DIn[0];
      stateD = DIn[1] ? HANDLER : NORMAL;
    end
    if (We && A2 == 5'd14) begin
      epcD = {DIn[31:2], 2'b00};
    end
    if (EXLClr) begin
      stateD = NORMAL;
    end
    // Exception entry is applied last so it wins on EXL and EPC.
    if (IntReq) begin
      stateD   = HANDLER;
      epcD     = {PC[31:2], 2'b00};
      excCodeD = intPend ? 5'd0 : ExcCodeIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ   <= NORMAL;
      imQ      <= '0;
      ieQ      <= 1'b0;
      ipQ      <= '0;
      excCodeQ <= '0;
      epcQ     <= '0;
    end else begin
      stateQ   <= stateD;
      imQ      <= imD;
      ieQ      <= ieD;
      ipQ      <= HWInt;
      excCodeQ <= excCodeD;
      epcQ     <= epcD;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badVAddrQ, badVAddrD;

  always_comb begin
    badVAddrD = badVAddrQ;
    if (IntReq && !intPend && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5)) begin
      badVAddrD = BadAddr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      badVAddrQ <= '0;
    end else begin
      badVAddrQ <= badVAddrD;
    end
  end

  assign badVAddrVal = badVAddrQ;
  assign unusedBits  = ^PC[1:0];
`else
  assign badVAddrVal = 32'b0;
  assign unusedBits  = ^{BadAddr, PC[1:0]};
`endif

  // Reads show pre-edge register state; no bypass from a same-cycle mtc0.
  always_comb begin
    DOut = 32'b0;
    case (A1)
      5'd8:    DOut = badVAddrVal;
      5'd12:   DOut = srVal;
      5'd13:   DOut = causeVal;
      5'd14:   DOut = epcQ;
      5'd15:   DOut = PRID_VAL;
      default: DOut = 32'b0;
    endcase
  end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed self-checking bench for cp0_int_ctrl; honours CP0_BADVADDR_EN for the BadVAddr read.
module tb_cp0_int_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic [4:0]  ExcCodeIn;
  logic        EXLSet, EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] BadAddr;
  logic        IntReq;
  logic [31:0] ExcPC, EPC, DOut;

  int errors = 0;
  int checks = 0;

  cp0_int_ctrl dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .We(We), .PC(PC),
    .ExcCodeIn(ExcCodeIn), .EXLSet(EXLSet), .EXLClr(EXLClr), .HWInt(HWInt),
    .BadAddr(BadAddr), .IntReq(IntReq), .ExcPC(ExcPC), .EPC(EPC), .DOut(DOut)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    We = 1'b0; A2 = 5'd0; DIn = 32'h0; EXLSet = 1'b0; EXLClr = 1'b0;
    ExcCodeIn = 5'd0; PC = 32'h0; BadAddr = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); HWInt = 6'd0; A1 = 5'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    A1 = 5'd12; #1; checks++;
    if (DOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_sr got=%h exp=%h", DOut, 32'h0); end
    A1 = 5'd13; #1; checks++;
    if (DOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_cause got=%h exp=%h", DOut, 32'h0); end
    A1 = 5'd14; #1; checks++;
    if (DOut !== 32'h0 || EPC !== 32'h0) begin errors++; $display("[TB] FAIL reset_epc got=%h/%h exp=0", DOut, EPC); end
    A1 = 5'd15; #1; checks++;
    if (DOut !== 32'h0000_4D50) begin errors++; $display("[TB] FAIL prid got=%h exp=%h", DOut, 32'h0000_4D50); end
    checks++;
    if (IntReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_intreq got=%b exp=0", IntReq); end
    checks++;
    if (ExcPC !== 32'h0000_4180) begin errors++; $display("[TB] FAIL excpc got=%h exp=%h", ExcPC, 32'h0000_4180); end
  endtask

  task automatic test_interrupt_entry();
    We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();
    idle(); HWInt = 6'b000001; PC = 32'h3008; #1; checks++;
    if (IntReq !== 1'b1) begin errors++; $display("[TB] FAIL int_req got=%b exp=1", IntReq); end
    tick();
    PC = 32'h0;
    A1 = 5'd12; #1; checks++;
    if (DOut !== 32'h0000_0403) begin errors++; $display("[TB] FAIL int_sr got=%h exp=%h", DOut, 32'h0000_0403); end
    A1 = 5'd14; #1; checks++;
    if (DOut !== 32'h3008) begin errors++; $display("[TB] FAIL int_epc got=%h exp=%h", DOut, 32'h3008); end
    A1 = 5'd13; #1; checks++;
    if (DOut !== 32'h0000_0400) begin errors++; $display("[TB] FAIL int_cause got=%h exp=%h", DOut, 32'h0000_0400); end
    checks++;
    if (IntReq !== 1'b0) begin errors++; $display("[TB] FAIL int_handler_req got=%b exp=0", IntReq); end
  endtask

  task automatic test_handler_ignore();
    EXLSet = 1'b1; ExcCodeIn = 5'd10; PC = 32'h3100; #1; checks++;
    if (IntReq !== 1'b0) begin errors++; $display("[TB] FAIL hdl_req got=%b exp=0", IntReq); end
    tick();
    idle();
    A1 = 5'd14; #1; checks++;
    if (EPC !== 32'h3008) begin errors++; $display("[TB] FAIL hdl_epc got=%h exp=%h", EPC, 32'h3008); end
    A1 = 5'd13; #1; checks++;
    if (DOut !== 32'h0000_0400) begin errors++; $display("[TB] FAIL hdl_cause got=%h exp=%h", DOut, 32'h0000_0400); end
    EXLClr = 1'b1;
    tick();
    idle();
    A1 = 5'd12; #1; checks++;
    if (DOut !== 32'h0000_0401) begin errors++; $display("[TB] FAIL eret_sr got=%h exp=%h", DOut, 32'h0000_0401); end
    checks++;
    if (IntReq !== 1'b1) begin errors++; $display("[TB] FAIL eret_req got=%b exp=1", IntReq); end
  endtask

  task automatic test_mask();
    HWInt = 6'd0; We = 1'b1; A2 = 5'd12; DIn = 32'h1;
    tick();
    idle(); HWInt = 6'b111111; #1; checks++;
    if (IntReq !== 1'b0) begin errors++; $display("[TB] FAIL mask_req got=%b exp=0", IntReq); end
    tick();
    A1 = 5'd13; #1; checks++;
    if (DOut !== 32'h0000_FC00) begin errors++; $display("[TB] FAIL mask_ip got=%h exp=%h", DOut, 32'h0000_FC00); end
    A1 = 5'd12; #1; checks++;
    if (DOut !== 32'h1) begin errors++; $display("[TB] FAIL mask_sr got=%h exp=%h", DOut, 32'h1); end
  endtask

  task automatic test_priority();
    HWInt = 6'd0; We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();
    idle(); HWInt = 6'b000001; EXLSet = 1'b1; ExcCodeIn = 5'd12; PC = 32'h3200; #1; checks++;
    if (IntReq !== 1'b1) begin errors++; $display("[TB] FAIL prio_req got=%b exp=1", IntReq); end
    tick();
    idle(); HWInt = 6'd0;
    A1 = 5'd13; #1; checks++;
    if (DOut !== 32'h0000_0400) begin errors++; $display("[TB] FAIL prio_cause got=%h exp=%h", DOut, 32'h0000_0400); end
    checks++;
    if (EPC !== 32'h3200) begin errors++; $display("[TB] FAIL prio_epc got=%h exp=%h", EPC, 32'h3200); end
    EXLClr = 1'b1;
    tick();
    idle(); EXLSet = 1'b1; ExcCodeIn = 5'd12; #1; checks++;
    if (IntReq !== 1'b1) begin errors++; $display("[TB] FAIL sync_req got=%b exp=1", IntReq); end
    tick();
    idle();
    A1 = 5'd13; #1; checks++;
    if (DOut !== 32'h0000_0030) begin errors++; $display("[TB] FAIL sync_cause got=%h exp=%h", DOut, 32'h0000_0030); end
    A1 = 5'd12; #1; checks++;
    if (DOut !== 32'h0000_0403) begin errors++; $display("[TB] FAIL sync_sr got=%h exp=%h", DOut, 32'h0000_0403); end
  endtask

  task automatic test_mtc0();
    We = 1'b1; A2 = 5'd14; DIn = 32'h0000_3007;
    tick();
    A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    A1 = 5'd14; #1; checks++;
    if (DOut !== 32'h0000_3004) begin errors++; $display("[TB] FAIL mtc0_epc got=%h exp=%h", DOut, 32'h0000_3004); end
    tick();
    A2 = 5'd15;
    A1 = 5'd13; #1; checks++;
    if (DOut !== 32'h0000_0030) begin errors++; $display("[TB] FAIL mtc0_cause_ro got=%h exp=%h", DOut, 32'h0000_0030); end
    tick();
    A1 = 5'd15; #1; checks++;
    if (DOut !== 32'h0000_4D50) begin errors++; $display("[TB] FAIL mtc0_prid_ro got=%h exp=%h", DOut, 32'h0000_4D50); end
    A2 = 5'd12; DIn = 32'h0000_0403; EXLClr = 1'b1;
    tick();
    idle();
    A1 = 5'd12; #1; checks++;
    if (DOut !== 32'h0000_0401) begin errors++; $display("[TB] FAIL clr_vs_mtc0 got=%h exp=%h", DOut, 32'h0000_0401); end
    We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0800; EXLSet = 1'b1; ExcCodeIn = 5'd8; PC = 32'h3300;
    tick();
    idle();
    A1 = 5'd12; #1; checks++;
    if (DOut !== 32'h0000_0802) begin errors++; $display("[TB] FAIL entry_vs_sr got=%h exp=%h", DOut, 32'h0000_0802); end
    A1 = 5'd13; #1; checks++;
    if (DOut !== 32'h0000_0020 || EPC !== 32'h3300) begin errors++; $display("[TB] FAIL entry_cause_epc got=%h/%h exp=%h/%h", DOut, EPC, 32'h20, 32'h3300); end
    EXLClr = 1'b1;
    tick();
    idle(); We = 1'b1; A2 = 5'd14; DIn = 32'h0000_5000; EXLSet = 1'b1; ExcCodeIn = 5'd8; PC = 32'h3400;
    tick();
    idle(); #1; checks++;
    if (EPC !== 32'h3400) begin errors++; $display("[TB] FAIL entry_vs_epc got=%h exp=%h", EPC, 32'h3400); end
    EXLClr = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_badvaddr();
    logic [31:0] expBad;
`ifdef CP0_BADVADDR_EN
    expBad = 32'h0000_1235;
`else
    expBad = 32'h0;
`endif
    EXLSet = 1'b1; ExcCodeIn = 5'd4; BadAddr = 32'h0000_1235; PC = 32'h3500;
    tick();
    idle();
    A1 = 5'd8; #1; checks++;
    if (DOut !== expBad) begin errors++; $display("[TB] FAIL badvaddr got=%h exp=%h", DOut, expBad); end
    A1 = 5'd13; #1; checks++;
    if (DOut !== 32'h0000_0010) begin errors++; $display("[TB] FAIL adel_cause got=%h exp=%h", DOut, 32'h0000_0010); end
    EXLClr = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset_override();
    reset = 1'b0; We = 1'b1; A2 = 5'd14; DIn = 32'h0000_7000; EXLSet = 1'b1; ExcCodeIn = 5'd6;
    PC = 32'h3600; HWInt = 6'b000011;
    tick();
    reset = 1'b1; idle(); HWInt = 6'd0;
    A1 = 5'd12; #1; checks++;
    if (DOut !== 32'h0) begin errors++; $display("[TB] FAIL ovr_sr got=%h exp=0", DOut); end
    A1 = 5'd13; #1; checks++;
    if (DOut !== 32'h0) begin errors++; $display("[TB] FAIL ovr_cause got=%h exp=0", DOut); end
    checks++;
    if (EPC !== 32'h0 || IntReq !== 1'b0) begin errors++; $display("[TB] FAIL ovr_epc_req got=%h/%b exp=0/0", EPC, IntReq); end
  endtask

  initial begin
    test_reset();
    test_interrupt_entry();
    test_handler_ignore();
    test_mask();
    test_priority();
    test_mtc0();
    test_badvaddr();
    test_reset_override();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
